// File: rtl/key_cmd_scheduler.sv
// PS/2 scan-code scheduler: decodes make/break bytes into per-player held-key state,
// emits framed paddle moves and queues control keys in a first-word-fall-through FIFO.
module key_cmd_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int MOVE_DIV   = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       done_i,
    input  logic [7:0] tasta_i,
    input  logic       frame_tick_i,
    input  logic       cmd_ready_i,
    output logic       cmd_valid_o,
    output logic [7:0] cmd_code_o,
    output logic [1:0] p1_move_o,
    output logic [1:0] p2_move_o,
    output logic       move_strobe_o,
    output logic       overflow_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DIV_W = 6;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;
    localparam logic [7:0] CODE_J     = 8'h3B;
    localparam logic [7:0] CODE_L     = 8'h4B;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ESC   = 8'h76;
    localparam logic [7:0] CODE_ONE   = 8'h16;
    localparam logic [7:0] CODE_TWO   = 8'h1E;

    function automatic logic [1:0] move_enc(input logic left, input logic right);
        logic [1:0] res;
        case ({right, left})
            2'b01:   res = 2'b01;
            2'b10:   res = 2'b10;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    logic                 done_q;
    logic                 brk_q, brk_d;
    logic [3:0]           held_q, held_d;
    logic [3:0]           ctrl_held_q, ctrl_held_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, waddr_s;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           p1_q, p1_d, p2_q, p2_d;
    logic                 strobe_q, strobe_d;

    logic                 byte_ev_s, key_ev_s;
    logic [3:0]           mv_hit_s, ct_hit_s;
    logic                 ctrl_accept_s, esc_accept_s, push_req_s;
    logic                 pop_s, full_s, push_ok_s, we_s;

    // Byte decode: prefix tracking and held-key bitmaps ({L,J,D,A} and {2,1,ESC,SPACE}).
    always_comb begin
        byte_ev_s   = done_i & ~done_q;
        key_ev_s    = byte_ev_s & (tasta_i != CODE_BRK) & (tasta_i != CODE_EXT);
        mv_hit_s    = {tasta_i == CODE_L, tasta_i == CODE_J, tasta_i == CODE_D, tasta_i == CODE_A};
        ct_hit_s    = {tasta_i == CODE_TWO, tasta_i == CODE_ONE, tasta_i == CODE_ESC, tasta_i == CODE_SPACE};
        brk_d       = brk_q;
        held_d      = held_q;
        ctrl_held_d = ctrl_held_q;
        if (byte_ev_s && (tasta_i == CODE_BRK)) begin
            brk_d = 1'b1;
        end else if (key_ev_s) begin
            brk_d = 1'b0;
        end else begin
            brk_d = brk_q;
        end
        if (key_ev_s && brk_q) begin
            held_d      = held_q & ~mv_hit_s;
            ctrl_held_d = ctrl_held_q & ~ct_hit_s;
        end else if (key_ev_s) begin
            held_d      = held_q | mv_hit_s;
            ctrl_held_d = ctrl_held_q | ct_hit_s;
        end else begin
            held_d      = held_q;
            ctrl_held_d = ctrl_held_q;
        end
        ctrl_accept_s = key_ev_s & ~brk_q & (|(ct_hit_s & ~ctrl_held_q));
        esc_accept_s  = ctrl_accept_s & ct_hit_s[1];
        push_req_s    = ctrl_accept_s & ~ct_hit_s[1];
    end

    // Command FIFO control; an accepted ESC replaces the whole contents.
    always_comb begin
        pop_s      = (count_q != {CNT_W{1'b0}}) & cmd_ready_i;
        full_s     = (count_q == DEPTH_C);
        push_ok_s  = 1'b0;
        we_s       = 1'b0;
        waddr_s    = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (esc_accept_s) begin
            we_s     = 1'b1;
            waddr_s  = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = PTR_W'(1);
            count_d  = CNT_W'(1);
        end else begin
            push_ok_s = push_req_s & (~full_s | pop_s);
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_ok_s) begin
                we_s     = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (push_req_s) begin
                overflow_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Frame divider; moves are sampled from held state before this cycle's byte lands.
    always_comb begin
        div_d    = div_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        strobe_d = 1'b0;
        if (frame_tick_i && (div_q == DIV_LAST)) begin
            div_d    = {DIV_W{1'b0}};
            p1_d     = move_enc(held_q[0], held_q[1]);
            p2_d     = move_enc(held_q[2], held_q[3]);
            strobe_d = 1'b1;
        end else if (frame_tick_i) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = div_q;
        end
    end

    // State registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            done_q      <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= 4'h0;
            ctrl_held_q <= 4'h0;
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
            div_q       <= {DIV_W{1'b0}};
            p1_q        <= 2'b00;
            p2_q        <= 2'b00;
            strobe_q    <= 1'b0;
        end else begin
            done_q      <= done_i;
            brk_q       <= brk_d;
            held_q      <= held_d;
            ctrl_held_q <= ctrl_held_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            div_q       <= div_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            strobe_q    <= strobe_d;
        end
    end

    // FIFO storage; stale words are masked at the output, so no reset is needed here.
    always_ff @(posedge clock_i) begin
        if (we_s && !reset_i) begin
            mem_q[waddr_s] <= tasta_i;
        end
    end

    assign cmd_valid_o   = (count_q != {CNT_W{1'b0}});
    assign cmd_code_o    = cmd_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign p1_move_o     = p1_q;
    assign p2_move_o     = p2_q;
    assign move_strobe_o = strobe_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: directed vector table on MOVE_DIV=1 and MOVE_DIV=3 instances,
// then random traffic compared against a key-state / queue reference model.
module tb_key_cmd_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, done = 1'b0, tick = 1'b0, rdy = 1'b0;
    logic [7:0] tasta = 8'h00;

    logic       v1, st1, ov1, v3, st3, ov3;
    logic [7:0] c1, c3;
    logic [1:0] a1, b1, a3, b3;

    key_cmd_scheduler #(.FIFO_DEPTH(4), .MOVE_DIV(1)) u1 (
        .clock_i(clk), .reset_i(rst), .done_i(done), .tasta_i(tasta),
        .frame_tick_i(tick), .cmd_ready_i(rdy), .cmd_valid_o(v1), .cmd_code_o(c1),
        .p1_move_o(a1), .p2_move_o(b1), .move_strobe_o(st1), .overflow_o(ov1));

    key_cmd_scheduler #(.FIFO_DEPTH(4), .MOVE_DIV(3)) u3 (
        .clock_i(clk), .reset_i(rst), .done_i(done), .tasta_i(tasta),
        .frame_tick_i(tick), .cmd_ready_i(rdy), .cmd_valid_o(v3), .cmd_code_o(c3),
        .p1_move_o(a3), .p2_move_o(b3), .move_strobe_o(st3), .overflow_o(ov3));

    typedef struct {
        logic       rst, done, tick, rdy;
        logic [7:0] tasta;
        logic       ev;
        logic [7:0] ec;
        logic [1:0] p1, p2;
        logic       st, ov;
        logic       c3, st3;
        logic [1:0] p13;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic [7:0] b, input logic t, input logic y,
                       input logic ev, input logic [7:0] ec, input logic [1:0] p1, input logic [1:0] p2,
                       input logic st, input logic ov, input logic c3 = 1'b0, input logic s3 = 1'b0,
                       input logic [1:0] p13 = 2'b00);
        vec_t v;
        v.rst = r; v.done = d; v.tasta = b; v.tick = t; v.rdy = y;
        v.ev = ev; v.ec = ec; v.p1 = p1; v.p2 = p2; v.st = st; v.ov = ov;
        v.c3 = c3; v.st3 = s3; v.p13 = p13;
        vq.push_back(v);
    endtask

    task automatic add_byte(input logic [7:0] b, input logic ev, input logic [7:0] ec,
                            input logic [1:0] p1, input logic [1:0] p2, input logic ov);
        add(1'b0, 1'b1, b, 1'b0, 1'b0, ev, ec, p1, p2, 1'b0, ov);
        add(1'b0, 1'b0, b, 1'b0, 1'b0, ev, ec, p1, p2, 1'b0, ov);
    endtask

    task automatic add_tick(input logic ev, input logic [7:0] ec, input logic [1:0] p1,
                            input logic [1:0] p2, input logic ov);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, ev, ec, p1, p2, 1'b1, ov);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ev, ec, p1, p2, 1'b0, ov);
    endtask

    // ---------------- reference model ----------------
    bit         m_prev, m_brk, m_ovf;
    bit         key_down [256];
    bit         ctrl_down[256];
    logic [7:0] m_q[$];
    int         m_ticks;
    logic [1:0] m1_p1, m1_p2, m3_p1, m3_p2;
    bit         m1_st, m3_st;

    function automatic logic [1:0] dir(input bit left, input bit right);
        if (left && !right) return 2'b01;
        if (right && !left) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_step();
        bit ev, rel;
        if (rst) begin
            m_prev = 0; m_brk = 0; m_ovf = 0; m_ticks = 0;
            foreach (key_down[k]) key_down[k] = 0;
            foreach (ctrl_down[k]) ctrl_down[k] = 0;
            m_q.delete();
            m1_p1 = 2'b00; m1_p2 = 2'b00; m3_p1 = 2'b00; m3_p2 = 2'b00;
            m1_st = 0; m3_st = 0;
            return;
        end
        ev = done && !m_prev;
        m_prev = done;
        m1_st = 0; m3_st = 0;
        if (tick) begin
            m_ticks++;
            m1_p1 = dir(key_down[8'h1C], key_down[8'h23]);
            m1_p2 = dir(key_down[8'h3B], key_down[8'h4B]);
            m1_st = 1;
            if (m_ticks % 3 == 0) begin
                m3_p1 = m1_p1; m3_p2 = m1_p2; m3_st = 1;
            end
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (ev) begin
            if (tasta == 8'hF0) m_brk = 1;
            else if (tasta != 8'hE0) begin
                rel = m_brk;
                m_brk = 0;
                if (tasta inside {8'h1C, 8'h23, 8'h3B, 8'h4B}) key_down[tasta] = !rel;
                if (tasta inside {8'h29, 8'h76, 8'h16, 8'h1E}) begin
                    if (rel) ctrl_down[tasta] = 0;
                    else if (!ctrl_down[tasta]) begin
                        ctrl_down[tasta] = 1;
                        if (tasta == 8'h76) begin
                            m_q.delete();
                            m_q.push_back(tasta);
                        end else if (m_q.size() < 4) m_q.push_back(tasta);
                        else m_ovf = 1;
                    end
                end
            end
        end
    endtask

    logic [7:0] ovs[10];
    logic [7:0] pool[12];

    initial begin
        // held-key make/break, opposing keys, typematic + handshake
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add_byte(8'h1C, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        add_byte(8'h4B, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        add_tick(1'b0, 8'h00, 2'b01, 2'b10, 1'b0);
        add_byte(8'hF0, 1'b0, 8'h00, 2'b01, 2'b10, 1'b0);
        add_byte(8'h1C, 1'b0, 8'h00, 2'b01, 2'b10, 1'b0);
        add_tick(1'b0, 8'h00, 2'b00, 2'b10, 1'b0);
        add_byte(8'h1C, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0);
        add_byte(8'h23, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0);
        add_tick(1'b0, 8'h00, 2'b00, 2'b10, 1'b0);
        for (int k = 0; k < 3; k++) add_byte(8'h29, 1'b1, 8'h29, 2'b00, 2'b10, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 1'b0);
        // overflow then ESC flush
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        ovs = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h29, 8'hF0, 8'h29, 8'h16};
        foreach (ovs[k]) add_byte(ovs[k], 1'b1, 8'h16, 2'b00, 2'b00, 1'b0);
        add_byte(8'h1E, 1'b1, 8'h16, 2'b00, 2'b00, 1'b1);
        add_byte(8'h76, 1'b1, 8'h76, 2'b00, 2'b00, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1);
        // reset mid-break, byte+tick in the same cycle, done held high
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add_byte(8'hF0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add_byte(8'h1C, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        add_tick(1'b0, 8'h00, 2'b01, 2'b00, 1'b0);
        add_byte(8'hF0, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0);
        add(1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 1'b0);
        add_tick(1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        add(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add_tick(1'b0, 8'h00, 2'b01, 2'b00, 1'b0);
        // divider: D held, seven ticks, MOVE_DIV=3 instance strobes after ticks 3 and 6
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        add_byte(8'h23, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b1, 1'b0,
                1'b1, (k % 3 == 0), (k >= 3) ? 2'b10 : 2'b00);
            add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b0, 1'b0,
                1'b1, 1'b0, (k >= 3) ? 2'b10 : 2'b00);
        end

        foreach (vq[i]) begin
            rst = vq[i].rst; done = vq[i].done; tasta = vq[i].tasta;
            tick = vq[i].tick; rdy = vq[i].rdy;
            @(posedge clk);
            #1;
            chk("cmd_valid", i, {7'd0, v1}, {7'd0, vq[i].ev});
            chk("cmd_code", i, c1, vq[i].ec);
            chk("p1_move", i, {6'd0, a1}, {6'd0, vq[i].p1});
            chk("p2_move", i, {6'd0, b1}, {6'd0, vq[i].p2});
            chk("move_strobe", i, {7'd0, st1}, {7'd0, vq[i].st});
            chk("overflow", i, {7'd0, ov1}, {7'd0, vq[i].ov});
            if (vq[i].c3) begin
                chk("div3_strobe", i, {7'd0, st3}, {7'd0, vq[i].st3});
                chk("div3_p1", i, {6'd0, a3}, {6'd0, vq[i].p13});
            end
        end

        // randomized traffic against the reference model
        pool = '{8'h1C, 8'h23, 8'h3B, 8'h4B, 8'h29, 8'h76, 8'h16, 8'h1E, 8'hF0, 8'hF0, 8'hE0, 8'h00};
        rst = 1'b1; done = 1'b0; tick = 1'b0; rdy = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 599) == 0);
            done  = $urandom_range(0, 1) == 1;
            tasta = pool[$urandom_range(0, 11)];
            if (tasta == 8'h00) tasta = 8'($urandom_range(0, 255));
            tick  = ($urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_valid", c, {7'd0, v1}, {7'd0, m_q.size() > 0});
            chk("rnd_code", c, c1, (m_q.size() > 0) ? m_q[0] : 8'h00);
            chk("rnd_overflow", c, {7'd0, ov1}, {7'd0, m_ovf});
            chk("rnd_p1", c, {6'd0, a1}, {6'd0, m1_p1});
            chk("rnd_p2", c, {6'd0, b1}, {6'd0, m1_p2});
            chk("rnd_strobe", c, {7'd0, st1}, {7'd0, m1_st});
            chk("rnd3_valid", c, {7'd0, v3}, {7'd0, m_q.size() > 0});
            chk("rnd3_code", c, c3, (m_q.size() > 0) ? m_q[0] : 8'h00);
            chk("rnd3_overflow", c, {7'd0, ov3}, {7'd0, m_ovf});
            chk("rnd3_p1", c, {6'd0, a3}, {6'd0, m3_p1});
            chk("rnd3_p2", c, {6'd0, b3}, {6'd0, m3_p2});
            chk("rnd3_strobe", c, {7'd0, st3}, {7'd0, m3_st});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
